// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: NOP presentation values, chip control levels, FSM states.
// Imported by the fetch stage, its optional instruction cache and the bench.
package if_stage_pkg;

    localparam logic [31:0] NOP_PC    = 32'h0000_0000;
    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam logic        ChipRst   = 1'b0;
    localparam logic        ChipStall = 1'b1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Fetch addresses are word aligned; the low two bits of any redirect are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/done handshake between the fetch stage (master) and the memory controller.
// mem_req/mem_addr are held until the single-cycle mem_done pulse that carries mem_ins.
interface if_stage_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_ins;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_done,
        input  mem_ins
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_done,
        output mem_ins
    );

endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache, present only when ICACHE_EN is defined.
// Combinational lookup, single-cycle write; valid bits cleared only by reset.
`ifdef ICACHE_EN
module icache
    import if_stage_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:2] i_lk_addr,
    output logic        o_lk_hit,
    output logic [31:0] o_lk_ins,
    input  logic        i_wr_en,
    input  logic [31:2] i_wr_addr,
    input  logic [31:0] i_wr_ins
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    logic [IW-1:0] w_lk_idx;
    logic [TW-1:0] w_lk_tag;
    logic [IW-1:0] w_wr_idx;
    logic [TW-1:0] w_wr_tag;

    assign w_lk_idx = i_lk_addr[IW+1:2];
    assign w_lk_tag = i_lk_addr[31:IW+2];
    assign w_wr_idx = i_wr_addr[IW+1:2];
    assign w_wr_tag = i_wr_addr[31:IW+2];

    assign o_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_lk_ins = r_data[w_lk_idx];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (rst_in == ChipRst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; a line is only read once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_ins;
        end
    end

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches over mem req/done, presents if_pc/if_ins; ICACHE_EN adds an I-cache.
// Miss: word shown the cycle after mem_done, hit: one cycle from S_REQ; stall/!rdy_in hold the shown word.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [31:0]      jump_target,
    if_stage_if.master       mem,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_ins
);

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_ins;
    logic         r_discard;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic         w_req_nxt;
    logic [31:0]  w_addr_nxt;
    logic [31:0]  w_if_pc_nxt;
    logic [31:0]  w_if_ins_nxt;
    logic         w_discard_nxt;

    logic         w_run;
    logic         w_jump;
    logic         w_hit;
    logic [31:0]  w_hit_ins;

    assign w_run  = rdy_in && (stall != ChipStall);
    assign w_jump = rdy_in && jump_en;

`ifdef ICACHE_EN
    logic w_fill;

    assign w_fill = (r_state == S_WAIT) && mem.mem_done && !r_discard && !w_jump;

    icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_lk_addr (r_pc[31:2]),
        .o_lk_hit  (w_hit),
        .o_lk_ins  (w_hit_ins),
        .i_wr_en   (w_fill),
        .i_wr_addr (r_mem_addr[31:2]),
        .i_wr_ins  (mem.mem_ins)
    );
`else
    assign w_hit     = 1'b0;
    assign w_hit_ins = NOP_INS;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_req_nxt     = r_mem_req;
        w_addr_nxt    = r_mem_addr;
        w_if_pc_nxt   = r_if_pc;
        w_if_ins_nxt  = r_if_ins;
        w_discard_nxt = r_discard;

        unique case (r_state)
            S_REQ: begin
                if (w_run) begin
                    if (w_hit) begin
                        w_if_pc_nxt  = r_pc;
                        w_if_ins_nxt = w_hit_ins;
                        w_state_nxt  = S_HOLD;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            // mem_done is a single pulse, so it is taken even while stalled.
            S_WAIT: begin
                if (mem.mem_done) begin
                    w_req_nxt = 1'b0;
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_if_pc_nxt  = r_pc;
                        w_if_ins_nxt = mem.mem_ins;
                        w_state_nxt  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_run) begin
                    w_if_pc_nxt  = NOP_PC;
                    w_if_ins_nxt = NOP_INS;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        // A redirect never aborts an outstanding fetch; it marks it for discard instead.
        if (w_jump) begin
            w_pc_nxt     = align_pc(jump_target);
            w_if_pc_nxt  = NOP_PC;
            w_if_ins_nxt = NOP_INS;
            w_addr_nxt   = r_mem_addr;
            if (r_state == S_WAIT && !mem.mem_done) begin
                w_discard_nxt = 1'b1;
                w_req_nxt     = r_mem_req;
                w_state_nxt   = S_WAIT;
            end else begin
                w_discard_nxt = 1'b0;
                w_req_nxt     = 1'b0;
                w_state_nxt   = S_REQ;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (rst_in == ChipRst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0000_0000;
            r_if_pc    <= NOP_PC;
            r_if_ins   <= NOP_INS;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_req  <= w_req_nxt;
            r_mem_addr <= w_addr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_ins   <= w_if_ins_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign if_pc        = r_if_pc;
    assign if_ins       = r_if_ins;

endmodule
